// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide sequencer for the HI/LO register path.
// Works on operand magnitudes one bit per edge; signs are restored in FIN.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // state | meaning
  // IDLE  | waiting for a start; outputs hold
  // RUN   | one shift/add or shift/subtract iteration per edge
  // FIN   | sign correction and result write, done on the next cycle
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t               state, stateNext;
  logic [CW-1:0]        iterCnt;
  logic                 isDiv, divByZero, signA, signB;
  logic [WIDTH-1:0]     magA, magB;
  logic [2*WIDTH-1:0]   acc;

  logic                 accept, acceptDz, lastIter;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [WIDTH:0]       multSum;
  logic [2*WIDTH-1:0]   multStep, divStep, prodFix;
  logic [WIDTH:0]       remShift;
  logic [WIDTH-1:0]     remDiff, quotFix, remFix;
  logic                 noBorrow;

  assign accept   = (state == IDLE) && (start_mult || start_div);
  assign acceptDz = !start_mult && (b == '0);
  assign lastIter = (iterCnt == CW'(WIDTH - 1));
  assign aMag     = a[WIDTH-1] ? -a : a;
  assign bMag     = b[WIDTH-1] ? -b : b;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
  assign multSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? magA : '0)};
  assign multStep = {multSum, acc[WIDTH-1:1]};

  // Divide (restoring): acc = {remainder, dividend/quotient}; shift left, trial subtract.
  assign remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign noBorrow = (remShift >= {1'b0, magB});
  assign remDiff  = remShift[WIDTH-1:0] - magB;
  assign divStep  = noBorrow ? {remDiff, acc[WIDTH-2:0], 1'b1}
                             : {acc[2*WIDTH-2:0], 1'b0};

  assign prodFix = (signA ^ signB) ? -acc : acc;
  assign quotFix = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix  = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = acceptDz ? FIN : RUN;
      RUN:     if (lastIter) stateNext = FIN;
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      iterCnt   <= '0;
      isDiv     <= 1'b0;
      divByZero <= 1'b0;
      signA     <= 1'b0;
      signB     <= 1'b0;
      magA      <= '0;
      magB      <= '0;
      acc       <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          isDiv     <= !start_mult;
          divByZero <= acceptDz;
          signA     <= a[WIDTH-1];
          signB     <= b[WIDTH-1];
          magA      <= aMag;
          magB      <= bMag;
          acc       <= start_mult ? {{WIDTH{1'b0}}, bMag} : {{WIDTH{1'b0}}, aMag};
          iterCnt   <= '0;
          div_zero  <= 1'b0;
        end
        RUN: begin
          iterCnt <= iterCnt + CW'(1);
          acc     <= isDiv ? divStep : multStep;
        end
        FIN: begin
          done <= 1'b1;
          if (divByZero) begin
            div_zero <= 1'b1;
          end else if (isDiv) begin
            hi_out <= remFix;
            lo_out <= quotFix;
          end else begin
            hi_out <= prodFix[2*WIDTH-1:WIDTH];
            lo_out <= prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: latency/arithmetic model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_mult_div_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_mult, start_div;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  mult_div_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts edges left until completion, computes results with plain arithmetic.
  int           remain = 0;
  bit           pendMult, pendDz;
  logic [W-1:0] pendA, pendB;
  logic         expDone = 0, expDz = 0;
  logic [W-1:0] expHi = '0, expLo = '0;

  always @(posedge clock) begin
    longint la, lb, p, q, r;
    if (reset) begin
      remain = 0; expDone = 0; expDz = 0; expHi = '0; expLo = '0;
    end else if (remain > 0) begin
      remain--;
      expDone = (remain == 0);
      if (remain == 0) begin
        la = longint'($signed(pendA));
        lb = longint'($signed(pendB));
        if (pendDz) expDz = 1'b1;
        else if (pendMult) begin
          p = la * lb;
          expHi = p[63:32]; expLo = p[31:0];
        end else begin
          q = la / lb; r = la % lb;
          expHi = r[31:0]; expLo = q[31:0];
        end
      end
    end else begin
      expDone = 0;
      if (start_mult || start_div) begin
        pendMult = start_mult;
        pendDz   = !start_mult && (b == '0);
        pendA    = a;
        pendB    = b;
        expDz    = 0;
        remain   = pendDz ? 1 : W + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmpEn) begin
      check("busy",     64'(busy),     64'(remain > 0));
      check("done",     64'(done),     64'(expDone));
      check("div_zero", 64'(div_zero), 64'(expDz));
      check("hi_out",   64'(hi_out),   64'(expHi));
      check("lo_out",   64'(lo_out),   64'(expLo));
    end
  end

  // Drives a one-cycle start; call #1 after an edge. Returns #1 after the accepting edge.
  task automatic startOp(input logic m, input logic d, input logic [W-1:0] aa, input logic [W-1:0] bb);
    start_mult = m; start_div = d; a = aa; b = bb;
    @(posedge clock); #1;
    start_mult = 0; start_div = 0; a = $urandom; b = $urandom;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock); #1;
      if (done) begin cycles = n; break; end
    end
    if (cycles < 0) $display("FAIL done_timeout: no done within %0d cycles", budget);
  endtask

  initial begin
    int cyc, extra;
    reset = 1; start_mult = 0; start_div = 0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1; reset = 0; cmpEn = 1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi",   64'(hi_out), 64'd0);
    check("rst_lo",   64'(lo_out), 64'd0);

    // 7 * -3
    startOp(1, 0, 32'd7, 32'hFFFFFFFD);
    check("busy_after_accept", 64'(busy), 64'd1);
    waitDone(40, cyc);
    check("lat_mult", 64'(cyc), 64'd33);
    check("m1_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("m1_lo", 64'(lo_out), 64'hFFFFFFEB);

    // min * min, then back-to-back div in the done cycle
    startOp(1, 0, 32'h80000000, 32'h80000000);
    waitDone(40, cyc);
    check("m2_hi", 64'(hi_out), 64'h40000000);
    check("m2_lo", 64'(lo_out), 64'h00000000);
    startOp(0, 1, 32'hFFFFFFF9, 32'd2);
    waitDone(40, cyc);
    check("lat_b2b", 64'(cyc), 64'd33);
    check("d1_lo", 64'(lo_out), 64'hFFFFFFFD);
    check("d1_hi", 64'(hi_out), 64'hFFFFFFFF);

    // 0x451 / 0x20 = 0x22 rem 0x11, then divide by zero
    startOp(0, 1, 32'h451, 32'h20);
    waitDone(40, cyc);
    check("d2_lo", 64'(lo_out), 64'h22);
    check("d2_hi", 64'(hi_out), 64'h11);
    startOp(0, 1, 32'd5, 32'd0);
    waitDone(5, cyc);
    check("lat_dz", 64'(cyc), 64'd1);
    check("dz_flag", 64'(div_zero), 64'd1);
    check("dz_hi", 64'(hi_out), 64'h11);
    check("dz_lo", 64'(lo_out), 64'h22);
    @(posedge clock); #1;
    check("dz_hold", 64'(div_zero), 64'd1);
    startOp(1, 0, 32'd2, 32'd3);
    check("dz_clear", 64'(div_zero), 64'd0);
    waitDone(40, cyc);
    check("m3_lo", 64'(lo_out), 64'd6);

    // overflow divide
    startOp(0, 1, 32'h80000000, 32'hFFFFFFFF);
    waitDone(40, cyc);
    check("lat_ovf", 64'(cyc), 64'd33);
    check("ovf_lo", 64'(lo_out), 64'h80000000);
    check("ovf_hi", 64'(hi_out), 64'h0);
    check("ovf_dz", 64'(div_zero), 64'd0);

    // both starts: mult wins; a start at iteration 5 is ignored
    startOp(1, 1, 32'd6, 32'd4);
    repeat (5) @(posedge clock);
    #1;
    startOp(0, 1, 32'd100, 32'd7);
    waitDone(40, cyc);
    check("lat_ignore", 64'(cyc), 64'd27);
    check("both_hi", 64'(hi_out), 64'd0);
    check("both_lo", 64'(lo_out), 64'd24);
    extra = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) extra++;
    end
    check("no_second_done", 64'(extra), 64'd0);

    // reset at iteration 10
    startOp(1, 0, 32'd9, 32'd9);
    repeat (10) @(posedge clock);
    #1; reset = 1;
    @(posedge clock); #1; reset = 0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi",   64'(hi_out), 64'd0);
    check("rst_mid_lo",   64'(lo_out), 64'd0);
    startOp(1, 0, 32'd3, 32'd5);
    waitDone(40, cyc);
    check("lat_after_rst", 64'(cyc), 64'd33);
    check("m4_lo", 64'(lo_out), 64'd15);
    check("m4_hi", 64'(hi_out), 64'd0);

    // a few signed divides with varied signs
    startOp(0, 1, 32'hFFFFFF9C, 32'd7);
    waitDone(40, cyc);
    check("d3_lo", 64'(lo_out), 64'hFFFFFFF2);
    check("d3_hi", 64'(hi_out), 64'hFFFFFFFE);
    startOp(0, 1, 32'd100, 32'hFFFFFFF9);
    waitDone(40, cyc);
    check("d4_lo", 64'(lo_out), 64'hFFFFFFF2);
    check("d4_hi", 64'(hi_out), 64'd2);

    repeat (3) @(posedge clock);
    #1; cmpEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
